// File: rtl/sweep_logic_system.sv
// rtl/sweep_logic_system.sv - exhaustive input sweep generator with registered logic results
// Holds each WIDTH-bit code for HOLD_CYCLES clocks and reports op-selected reductions of it.
module sweep_logic_system #(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 100,
  parameter int HOLD_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] vec_out,
  output logic             out1,
  output logic             out2,
  output logic             sample_v,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

  localparam logic [WIDTH-1:0]  ALL_ONES  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec_out  <= '0;
      hold_cnt <= '0;
      loaded   <= 1'b0;
      out1     <= 1'b0;
      out2     <= 1'b0;
      sample_v <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      out2 <= |vec_out;
      case (op)
        2'b00:   out1 <= &vec_out;
        2'b01:   out1 <= |vec_out;
        2'b10:   out1 <= ^vec_out;
        default: out1 <= ~&vec_out;
      endcase
      // loaded marks the clk a new code appeared; sample_v follows it once out1/out2 catch up
      loaded   <= 1'b0;
      sample_v <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            vec_out  <= '0;
            hold_cnt <= '0;
            loaded   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sample_v <= loaded;
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (vec_out != ALL_ONES) begin
                vec_out <= vec_out + WIDTH'(1);
                loaded  <= 1'b1;
              end else if (mode) begin
                vec_out <= '0;
                loaded  <= 1'b1;
              end else begin
                state <= DONE_S;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_logic_system.sv
// tb/tb_sweep_logic_system.sv - directed checks of sweep_logic_system in three configurations
module tb_sweep_logic_system;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] op;
  logic       start_a, stop_a, start_b, stop_b, start_c, stop_c;

  logic [1:0] vec_a, vec_b;
  logic [3:0] vec_c;
  logic out1_a, out2_a, sv_a, busy_a, done_a;
  logic out1_b, out2_b, sv_b, busy_b, done_b;
  logic out1_c, out2_c, sv_c, busy_c, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sweep_logic_system #(.WIDTH(2), .HOLD_CYCLES(4), .HOLD_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .mode(mode), .op(op),
    .vec_out(vec_a), .out1(out1_a), .out2(out2_a), .sample_v(sv_a), .busy(busy_a), .done(done_a));

  sweep_logic_system #(.WIDTH(2), .HOLD_CYCLES(2), .HOLD_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .mode(mode), .op(op),
    .vec_out(vec_b), .out1(out1_b), .out2(out2_b), .sample_v(sv_b), .busy(busy_b), .done(done_b));

  sweep_logic_system #(.WIDTH(4), .HOLD_CYCLES(1), .HOLD_W(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c), .mode(mode), .op(op),
    .vec_out(vec_c), .out1(out1_c), .out2(out2_c), .sample_v(sv_c), .busy(busy_c), .done(done_c));

  typedef struct {
    logic [1:0] op;
    logic       exp1;
  } op_vec_t;

  op_vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] pv, v;
    logic       prev1;
    int         dcount, scount;

    tbl[0] = '{2'b00, 1'b0};
    tbl[1] = '{2'b01, 1'b1};
    tbl[2] = '{2'b10, 1'b1};
    tbl[3] = '{2'b11, 1'b1};
    tbl[4] = '{2'b00, 1'b0};

    rst_n = 1'b0; mode = 1'b0; op = 2'b00;
    start_a = 0; stop_a = 0; start_b = 0; stop_b = 0; start_c = 0; stop_c = 0;
    step(); step();
    chk("reset_a", {30'd0, vec_a, out1_a, out2_a, sv_a, busy_a, done_a} >> 2, 32'd0);
    chk("reset_a_lo", {31'd0, busy_a | done_a}, 32'd0);
    chk("reset_c", {23'd0, vec_c, out1_c, out2_c, sv_c, busy_c, done_c}, 32'd0);
    rst_n = 1'b1;
    step();

    // single sweep, WIDTH=2 HOLD=4, AND-reduce
    start_a = 1; step(); start_a = 0;
    chk("t1_entry", {25'd0, vec_a, out1_a, out2_a, sv_a, busy_a, done_a}, {25'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int k = 1; k <= 17; k++) begin
      step();
      pv = ((k - 1) / 4 > 3) ? 2'd3 : 2'((k - 1) / 4);
      v  = (k < 16) ? 2'(k / 4) : 2'd3;
      chk($sformatf("t1_cycle%0d", k), {25'd0, vec_a, out1_a, out2_a, sv_a, busy_a, done_a},
          {25'd0, v, (pv == 2'd3), (pv != 2'd0), (((k - 1) % 4 == 0) && k <= 16), (k < 16), (k == 16)});
    end

    // continuous sweep, WIDTH=2 HOLD=2, then stop at vec=2
    mode = 1'b1;
    start_b = 1; step(); start_b = 0;
    dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done_b) dcount++;
      chk($sformatf("t2_vec%0d", k), {30'd0, vec_b}, 32'((k / 2) % 4));
    end
    chk("t2_no_done", dcount, 0);
    chk("t2_busy", {31'd0, busy_b}, 32'd1);
    stop_b = 1; step(); stop_b = 0;
    chk("t2_stop", {28'd0, vec_b, busy_b, done_b}, {28'd0, 2'd2, 1'b0, 1'b0});
    dcount = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done_b || sv_b || busy_b || vec_b != 2'd2) dcount++;
    end
    chk("t2_idle_quiet", dcount, 0);

    // op sweep at frozen vec=2'b10
    prev1 = out1_b;
    chk("t3_initial", {31'd0, prev1}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      op = tbl[i].op;
      #1;
      chk($sformatf("t3_hold%0d", i), {31'd0, out1_b}, {31'd0, prev1});
      step();
      chk($sformatf("t3_op%0d", i), {30'd0, out1_b, out2_b}, {30'd0, tbl[i].exp1, 1'b1});
      prev1 = tbl[i].exp1;
    end
    mode = 1'b0;

    // start held through a whole sweep
    start_a = 1;
    dcount = 0;
    step();
    for (int k = 1; k <= 18; k++) begin
      step();
      if (done_a) dcount++;
    end
    chk("t4_one_done", dcount, 1);
    chk("t4_restart", {29'd0, vec_a, busy_a}, {29'd0, 2'd0, 1'b1});
    start_a = 0; stop_a = 1; step();
    chk("t4_stopped", {31'd0, busy_a}, 32'd0);
    start_a = 1; step(); step();
    chk("t4_start_stop_idle", {31'd0, busy_a}, 32'd0);
    start_a = 0; stop_a = 0;
    step();

    // async reset mid-run at vec=1, hold_cnt=2
    start_a = 1; step(); start_a = 0;
    for (int k = 1; k <= 6; k++) step();
    chk("t5_pre", {29'd0, vec_a, busy_a}, {29'd0, 2'd1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("t5_async", {25'd0, vec_a, out1_a, out2_a, sv_a, busy_a, done_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done_a || busy_a) dcount++;
    end
    chk("t5_quiet", dcount, 0);
    start_a = 1; step(); start_a = 0;
    chk("t5_restart", {29'd0, vec_a, busy_a}, {29'd0, 2'd0, 1'b1});
    step();
    chk("t5_sample", {31'd0, sv_a}, 32'd1);
    stop_a = 1; step(); stop_a = 0;

    // WIDTH=4 HOLD=1 single sweep
    start_c = 1; step(); start_c = 0;
    chk("t6_entry", {26'd0, vec_c, busy_c, sv_c}, {26'd0, 4'd0, 1'b1, 1'b0});
    scount = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (sv_c) scount++;
      if (k <= 15) chk($sformatf("t6_vec%0d", k), {27'd0, vec_c, done_c}, {27'd0, 4'(k), 1'b0});
      if (k == 16) chk("t6_done", {26'd0, vec_c, done_c, busy_c}, {26'd0, 4'd15, 1'b1, 1'b0});
      if (k == 17) chk("t6_done_pulse", {30'd0, done_c, sv_c}, 32'd0);
    end
    chk("t6_sample_count", scount, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
